gcd_engine: RTL
===============

Name: gcd_engine

Overview:
- Parametrised successor to the fixed 8-bit, externally-controlled GCD datapath.
- Integrates datapath, controller FSM and registered zero/negative status flags into one self-sequencing engine.
- Operands are accepted over a valid/ready handshake; a result is returned over a second handshake.
- Supports subtractive (Euclid) and binary (Stein) modes, with iteration count, timeout and error reporting.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
MAX_ITER, 2**WIDTH, RUN-cycle limit before timeout abort (>=1)
ITER_W, $clog2(MAX_ITER+1), iteration counter width (derived; do not override)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start_valid  input  1  operands a_in/b_in/mode valid
start_ready  output  1  engine can accept operands (IDLE only)
a_in  input  WIDTH  operand A, unsigned
b_in  input  WIDTH  operand B, unsigned
mode  input  1  0 = subtractive, 1 = binary; sampled at accept
result_valid  output  1  result/status valid (DONE)
result_ready  input  1  consumer accepts result
result  output  WIDTH  gcd(A,B); 0 on error
iter_count  output  ITER_W  RUN cycles used for this computation
zero_flag  output  1  registered: last comparison found A==B
neg_flag  output  1  registered: last comparison found A<B
error  output  1  both operands zero, or timeout

Behaviour:
- One clock; reset is asynchronous and active-low. While reset=0: state=IDLE, all outputs 0 except start_ready=1; internal A/B/K/mode cleared. Reset mid-operation aborts with no result produced.
- States: IDLE, CHECK, RUN, DONE.
- IDLE: start_ready=1. On start_valid&&start_ready: latch A<=a_in, B<=b_in, mode; K<=0, iter_count<=0; clear zero_flag, neg_flag, error, result; go to CHECK.
- CHECK (1 cycle):
  - A==0 && B==0: result=0, error=1, go to DONE.
  - Exactly one operand zero: result=A|B, error=0, go to DONE.
  - Otherwise go to RUN.
- RUN, applied in priority order, one step per cycle:
  - Timeout: if iter_count==MAX_ITER, go to DONE with error=1, result=0; flags hold.
  - Otherwise iter_count++ and flags update from the current A,B: zero_flag<=(A==B), neg_flag<=(A<B).
  - Subtractive mode: A==B -> result=A, go to DONE; A>B -> A<=A-B; else B<=B-A.
  - Binary mode:
    - A==B -> result=A<<K, go to DONE.
    - Both even -> A>>=1, B>>=1, K++.
    - A even -> A>>=1.
    - B even -> B>>=1.
    - A>B -> A<=(A-B)>>1; else B<=(B-A)>>1.
  - K width is $clog2(WIDTH)+1. A<<K never exceeds the original operands, so there is no overflow.
  - All subtractions are unsigned WIDTH-bit and never underflow because the compare precedes them.
- DONE: result_valid=1. result, iter_count, flags and error are held stable until result_ready=1. On that handshake go to IDLE; result_valid drops next cycle.
- start_ready=0 in CHECK, RUN and DONE. start_valid is ignored there; it is not queued.
- Minimum turnaround, accept to next accept: 1 (CHECK) + N (RUN) + 1 (DONE, ready high) + 1 (IDLE).
- Outputs are registered; no combinational path from inputs to outputs except start_ready, which depends only on state.

Test Plan:
- Subtractive, a=48, b=18, result_ready=1 -> result=6, iter_count=5, zero_flag=1, neg_flag=0, error=0; result_valid asserted for 1 cycle.
- Binary, a=48, b=18 -> result=6, iter_count=6, zero_flag=1, error=0.
- Zero operands:
  - a=0, b=35 -> result=35, iter_count=0, error=0, DONE reached 2 cycles after accept.
  - a=0, b=0 -> result=0, error=1.
- Limits, WIDTH=8:
  - Subtractive, a=255, b=1, default MAX_ITER=256 -> result=1, iter_count=255, error=0.
  - Same with MAX_ITER=100 -> result=0, error=1, iter_count=100.
- Backpressure: hold result_ready=0 for 10 cycles in DONE while pulsing start_valid with new operands -> result_valid stays 1, outputs constant, start_ready=0, new operands ignored. Raise result_ready -> IDLE next cycle, then a fresh accept works.
- Reset: assert reset=0 mid-RUN (a=200, b=3) -> immediately result_valid=0, flags/error/iter_count=0, start_ready=1. Release reset -> a new gcd(12,8) returns 4.

Source files
------------

// File: rtl/gcd_engine.sv
// gcd_engine: self-sequencing greatest-common-divisor engine.
// Operands arrive on a valid/ready handshake. The result leaves on a second
// valid/ready handshake. Two algorithms are available, chosen per operation:
//   mode = 0 : subtractive Euclid (subtract the smaller operand from the larger)
//   mode = 1 : binary Stein (strip shared factors of two, then subtract and halve)
// Each RUN cycle performs one algorithm step and increments iter_count.
// A run that reaches MAX_ITER steps is aborted with error set.
// A start with both operands zero is also reported as an error.
module gcd_engine #(
   parameter int WIDTH    = 8,
   parameter int MAX_ITER = 2**WIDTH,
   parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [WIDTH-1:0]  a_in,
   input  logic [WIDTH-1:0]  b_in,
   input  logic              mode,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [WIDTH-1:0]  result,
   output logic [ITER_W-1:0] iter_count,
   output logic              zero_flag,
   output logic              neg_flag,
   output logic              error
);

   // Width of the shared power-of-two exponent used in binary mode.
   // It must be able to hold any count from 0 to WIDTH.
   localparam int K_W = $clog2(WIDTH) + 1;

   // Step budget, sized to the iteration counter for the timeout compare.
   localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [K_W-1:0]   k_q;
   logic             mode_q;

   // Compare results and differences of the working operands.
   // Both the flag update and the step selection share these.
   logic             a_eq_b;
   logic             a_lt_b;
   logic             a_is_zero;
   logic             b_is_zero;
   logic [WIDTH-1:0] a_minus_b;
   logic [WIDTH-1:0] b_minus_a;

   assign a_eq_b    = (a_q == b_q);
   assign a_lt_b    = (a_q < b_q);
   assign a_is_zero = (a_q == '0);
   assign b_is_zero = (b_q == '0);
   // Each difference is only used when its minuend is the larger operand.
   // For that reason it never wraps.
   assign a_minus_b = a_q - b_q;
   assign b_minus_a = b_q - a_q;

   // Acceptance is possible only in IDLE. The signal depends on state alone,
   // so there is no combinational path from any input.
   assign start_ready = (state == S_IDLE);

   // Next operand values and completion for one RUN step of the selected algorithm.
   logic [WIDTH-1:0] a_step;
   logic [WIDTH-1:0] b_step;
   logic [K_W-1:0]   k_step;
   logic             step_done;
   logic [WIDTH-1:0] step_result;

   // One algorithm step, evaluated from the current operands.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the branches below leaves a value undriven (no latch).
      a_step      = a_q;
      b_step      = b_q;
      k_step      = k_q;
      step_done   = 1'b0;
      step_result = '0;

      if (a_eq_b) begin
         // Equal operands end the run in both modes.
         // Binary mode restores the shared factor of two stripped earlier.
         // That product never exceeds either original operand.
         step_done   = 1'b1;
         step_result = mode_q ? (a_q << k_q) : a_q;
      end else if (!mode_q) begin
         // Euclid: replace the larger operand with the difference.
         if (a_lt_b) begin
            b_step = b_minus_a;
         end else begin
            a_step = a_minus_b;
         end
      end else begin
         // Stein: handle even operands first, then subtract the two odd operands and halve.
         if (!a_q[0] && !b_q[0]) begin
            a_step = a_q >> 1;
            b_step = b_q >> 1;
            k_step = k_q + K_W'(1);
         end else if (!a_q[0]) begin
            a_step = a_q >> 1;
         end else if (!b_q[0]) begin
            b_step = b_q >> 1;
         end else if (!a_lt_b) begin
            // The difference of two odd numbers is even, so this halving loses nothing.
            a_step = a_minus_b >> 1;
         end else begin
            b_step = b_minus_a >> 1;
         end
      end
   end

   // Controller FSM with the operand datapath and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: the asynchronous reset clears every register here, including the
      // working operands. A reset in mid-run therefore leaves no stale state
      // behind.
      if (!reset) begin
         state        <= S_IDLE;
         a_q          <= '0;
         b_q          <= '0;
         k_q          <= '0;
         mode_q       <= 1'b0;
         result_valid <= 1'b0;
         result       <= '0;
         iter_count   <= '0;
         zero_flag    <= 1'b0;
         neg_flag     <= 1'b0;
         error        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout. Every register updates
         // from the values present before this edge, whatever the statement
         // order.
         case (state)
            S_IDLE: begin
               if (start_valid) begin
                  a_q        <= a_in;
                  b_q        <= b_in;
                  mode_q     <= mode;
                  k_q        <= '0;
                  iter_count <= '0;
                  zero_flag  <= 1'b0;
                  neg_flag   <= 1'b0;
                  error      <= 1'b0;
                  result     <= '0;
                  state      <= S_CHECK;
               end
            end

            S_CHECK: begin
               // Zero operands are resolved here, so RUN only sees non-zero values.
               if (a_is_zero && b_is_zero) begin
                  result       <= '0;
                  error        <= 1'b1;
                  result_valid <= 1'b1;
                  state        <= S_DONE;
               end else if (a_is_zero || b_is_zero) begin
                  result       <= a_q | b_q;
                  error        <= 1'b0;
                  result_valid <= 1'b1;
                  state        <= S_DONE;
               end else begin
                  state <= S_RUN;
               end
            end

            S_RUN: begin
               if (iter_count == ITER_LIMIT) begin
                  // Out of budget. Abort with the flags still showing the last compare.
                  result       <= '0;
                  error        <= 1'b1;
                  result_valid <= 1'b1;
                  state        <= S_DONE;
               end else begin
                  iter_count <= iter_count + ITER_W'(1);
                  zero_flag  <= a_eq_b;
                  neg_flag   <= a_lt_b;
                  a_q        <= a_step;
                  b_q        <= b_step;
                  k_q        <= k_step;
                  if (step_done) begin
                     result       <= step_result;
                     result_valid <= 1'b1;
                     state        <= S_DONE;
                  end
               end
            end

            S_DONE: begin
               // Hold every output until the consumer takes the result.
               if (result_ready) begin
                  result_valid <= 1'b0;
                  state        <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
